// File: rtl/ttl_cen_gen_sync_pkg.sv
// Shared types for the fractional clock-enable generator: the per-edge action
// chosen by the accumulator decision logic.
package ttl_cen_gen_sync_pkg;

  typedef enum logic [2:0] {
    ACT_HOLD       = 3'd0,
    ACT_SYNC       = 3'd1,
    ACT_ADD        = 3'd2,
    ACT_STEP_WRAP  = 3'd3,
    ACT_CLAMP      = 3'd4,
    ACT_FORCE_WRAP = 3'd5
  } cen_act_e;

  // Actions that flip the generated level.
  function automatic logic act_toggles(input cen_act_e act);
    return (act == ACT_STEP_WRAP) || (act == ACT_CLAMP) || (act == ACT_FORCE_WRAP);
  endfunction

endpackage

// File: rtl/ttl_cen_gen_sync.sv
// Fractional clock-enable generator: phase accumulator producing a square-wave
// enable level at Num/(2*Den) of Clk, plus registered Rise/Fall strobes.
module ttl_cen_gen_sync
  import ttl_cen_gen_sync_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Sync,
  input  logic [WIDTH-1:0] Num,
  input  logic [WIDTH-1:0] Den,
  output logic             CenOut,
  output logic             Rise,
  output logic             Fall
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cen_q, cen_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [WIDTH:0]   sum;
  cen_act_e         act;
  logic             toggle;

  // One extra bit so acc + Num never overflows before the modulus compare.
  assign sum = {1'b0, acc_q} + {1'b0, Num};

  always_comb begin
    act = ACT_HOLD;
    if (Sync) begin
      act = ACT_SYNC;
    end else if (Den == '0) begin
      act = ACT_HOLD;
    end else if (!En) begin
      act = ACT_HOLD;
    end else if (acc_q >= Den) begin
      act = ACT_FORCE_WRAP;
    end else if (Num >= Den) begin
      act = ACT_CLAMP;
    end else if (sum >= {1'b0, Den}) begin
      act = ACT_STEP_WRAP;
    end else begin
      act = ACT_ADD;
    end
  end

  assign toggle = act_toggles(act);

  always_comb begin
    acc_d  = acc_q;
    cen_d  = cen_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    case (act)
      ACT_SYNC: begin
        acc_d  = '0;
        cen_d  = 1'b0;
        fall_d = cen_q;
      end
      ACT_ADD: begin
        acc_d = sum[WIDTH-1:0];
      end
      // The true difference is below Den, so WIDTH-bit modular subtraction is exact.
      ACT_STEP_WRAP: begin
        acc_d = sum[WIDTH-1:0] - Den;
      end
      ACT_CLAMP, ACT_FORCE_WRAP: begin
        acc_d = '0;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
    if (toggle) begin
      cen_d  = ~cen_q;
      rise_d = ~cen_q;
      fall_d = cen_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_q  <= '0;
      cen_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cen_q  <= cen_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign CenOut = cen_q;
  assign Rise   = rise_q;
  assign Fall   = fall_q;

endmodule

// File: tb/tb_ttl_cen_gen_sync.sv
// Directed bench for ttl_cen_gen_sync: the driver pushes hand-computed
// {CenOut,Rise,Fall} per edge; a monitor pops and compares after each edge.
module tb_ttl_cen_gen_sync;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic       Sync;
  logic [7:0] Num;
  logic [7:0] Den;
  logic       CenOut;
  logic       Rise;
  logic       Fall;

  logic [2:0] exp_q[$];
  string      name_q[$];
  int         checks;
  int         failures;

  ttl_cen_gen_sync #(.WIDTH(8)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .En     (En),
    .Sync   (Sync),
    .Num    (Num),
    .Den    (Den),
    .CenOut (CenOut),
    .Rise   (Rise),
    .Fall   (Fall)
  );

  // Clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {cen,rise,fall}=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Driver: applies inputs on the falling edge and queues the response expected after the next rising edge.
  task automatic step(input logic rst, input logic en, input logic sync,
                      input logic [7:0] num, input logic [7:0] den,
                      input logic [2:0] exp, input string nm);
    @(negedge Clk);
    Reset = rst;
    En    = en;
    Sync  = sync;
    Num   = num;
    Den   = den;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [2:0] e;
    string      n;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, {CenOut, Rise, Fall}, e);
      end
    end
  end

  // Toggle pattern for Num=3, Den=8 over one 8-edge block: toggles at edges 3, 6, 8.
  logic [7:0] tog38;

  initial begin
    logic cen;
    checks   = 0;
    failures = 0;
    tog38    = 8'b1010_0100;
    Reset = 1'b1;
    En    = 1'b1;
    Sync  = 1'b0;
    Num   = 8'd1;
    Den   = 8'd4;

    // Held reset: all outputs low.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'd1, 8'd4, 3'b000, "reset_hold");

    // Num=1 Den=4: toggle every 4th edge, Rise at 4, Fall at 8.
    for (int i = 1; i <= 16; i++)
      step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4,
           {((i / 4) % 2) == 1, (i % 8) == 4, (i % 8) == 0}, "n1_d4");

    // Num=3 Den=8: acc 3,6,1*,4,7,2*,5,0*; 24 edges give 9 toggles.
    cen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (tog38[i % 8]) begin
        cen = ~cen;
        step(1'b0, 1'b1, 1'b0, 8'd3, 8'd8, {cen, cen, ~cen}, "n3_d8_tog");
      end else begin
        step(1'b0, 1'b1, 1'b0, 8'd3, 8'd8, {cen, 2'b00}, "n3_d8_hold");
      end
    end
    // CenOut is now 1 after 9 toggles.

    // Clamp: Num>=Den toggles every enabled edge.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'd5, 8'd5, 3'b001, "clamp_eq_fall");
      step(1'b0, 1'b1, 1'b0, 8'd5, 8'd5, 3'b110, "clamp_eq_rise");
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'd9, 8'd4, 3'b001, "clamp_gt_fall");
      step(1'b0, 1'b1, 1'b0, 8'd9, 8'd4, 3'b110, "clamp_gt_rise");
    end

    // Num=1 Den=10 up to acc=7, then Den=4 forces a wrap.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'd1, 8'd10, 3'b100, "n1_d10");
    step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b001, "forced_wrap");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b000, "post_wrap");
    step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b110, "post_wrap_rise");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b100, "pre_sync");

    // Sync while high gives Fall; Sync while low gives no strobe; acc restarts at 0.
    step(1'b0, 1'b1, 1'b1, 8'd1, 8'd4, 3'b001, "sync_high");
    step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b000, "after_sync");
    step(1'b0, 1'b1, 1'b1, 8'd1, 8'd4, 3'b000, "sync_low");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b000, "sync_restart");
    step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b110, "sync_restart_rise");

    // En low freezes acc and level: the wrap comes on the 4th enabled edge.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b100, "pre_freeze");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd1, 8'd4, 3'b100, "en_low");
    step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b100, "resume");
    step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b001, "resume_fall");

    // Den=0 halts even with En high.
    step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b000, "pre_den0");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 3'b000, "den0_hold");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b000, "post_den0");
    step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b110, "post_den0_rise");

    // Num=0: no advance, level holds high.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'd0, 8'd4, 3'b100, "num0_hold");

    // Async reset mid-cycle clears immediately.
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("async_reset", {CenOut, Rise, Fall}, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b000, "after_reset");
    step(1'b0, 1'b1, 1'b0, 8'd1, 8'd4, 3'b110, "after_reset_rise");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
